// File: rtl/pong_pkg.sv
// Shared geometry, encodings and helpers for the Pong game controller.
package pong_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned BALL_SZ  = 4;
    localparam int unsigned PADDLE_W = 2;
    localparam int unsigned PADDLE_H = 15;

    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 7;
    localparam int unsigned SCORE_W = 5;

    localparam logic [X_W-1:0] X_PADDLE      = 8'd4;
    localparam logic [X_W-1:0] X_AI          = 8'd154;
    localparam logic [X_W-1:0] X_CENTRE      = 8'd78;
    localparam logic [Y_W-1:0] Y_CENTRE      = 7'd58;
    localparam logic [Y_W-1:0] Y_PADDLE_INIT = 7'd52;
    localparam logic [Y_W-1:0] Y_PADDLE_MAX  = 7'(SCREEN_H - PADDLE_H);
    localparam logic [Y_W-1:0] Y_BALL_MAX    = 7'(SCREEN_H - BALL_SZ);
    localparam logic [X_W-1:0] X_BALL_MAX    = 8'(SCREEN_W - BALL_SZ);
    localparam logic [X_W-1:0] X_PADDLE_HIT  = 8'(32'(X_PADDLE) + PADDLE_W);
    localparam logic [X_W-1:0] X_AI_HIT      = 8'(32'(X_AI) - BALL_SZ);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE     = 2'd1,
        ST_PLAY      = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    // PH_BALL: ball step pending on the next edge; PH_HOLD: serve tick, nothing pending.
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_BALL = 2'd1,
        PH_HOLD = 2'd2
    } phase_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           dx_pos;
        logic           dy_pos;
    } ball_t;

    function automatic logic y_overlap(input logic [Y_W-1:0] yb, input logic [Y_W-1:0] yp);
        return (9'(yb) + 9'(BALL_SZ) > 9'(yp)) && (9'(yb) < 9'(yp) + 9'(PADDLE_H));
    endfunction

endpackage

// File: rtl/pong_game_controller_if.sv
// Frame control inputs and sprite position/score outputs of the game controller.
interface pong_game_controller_if;
    import pong_pkg::*;

    logic                 frame_tick;
    logic                 btn_up;
    logic                 btn_down;
    logic                 start;
    logic [X_W-1:0]       x_ball;
    logic [Y_W-1:0]       y_ball;
    logic [X_W-1:0]       x_paddle;
    logic [Y_W-1:0]       y_paddle;
    logic [X_W-1:0]       x_ai;
    logic [Y_W-1:0]       y_ai;
    logic [SCORE_W-1:0]   player_score;
    logic [SCORE_W-1:0]   ai_score;
    logic                 game_over;

    modport master (
        output frame_tick, btn_up, btn_down, start,
        input  x_ball, y_ball, x_paddle, y_paddle, x_ai, y_ai,
               player_score, ai_score, game_over
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, start,
        output x_ball, y_ball, x_paddle, y_paddle, x_ai, y_ai,
               player_score, ai_score, game_over
    );
endinterface

// File: rtl/pong_ball_physics.sv
// Combinational ball step: wall/paddle bounces, movement and point detection.
module pong_ball_physics
    import pong_pkg::*;
(
    input  ball_t          ball_i,
    input  logic [Y_W-1:0] y_paddle_i,
    input  logic [Y_W-1:0] y_ai_i,
    output ball_t          ball_o,
    output logic           point_ai_c,
    output logic           point_player_c
);

    always_comb begin
        ball_o         = ball_i;
        point_ai_c     = 1'b0;
        point_player_c = 1'b0;
        if (!ball_i.dx_pos && ball_i.x == '0) begin
            point_ai_c    = 1'b1;
            ball_o.x      = X_CENTRE;
            ball_o.y      = Y_CENTRE;
            ball_o.dx_pos = 1'b0;
            ball_o.dy_pos = ~ball_i.dy_pos;
        end else if (ball_i.dx_pos && ball_i.x == X_BALL_MAX) begin
            point_player_c = 1'b1;
            ball_o.x       = X_CENTRE;
            ball_o.y       = Y_CENTRE;
            ball_o.dx_pos  = 1'b1;
            ball_o.dy_pos  = ~ball_i.dy_pos;
        end else begin
            // A bounce reverses direction and holds that axis for this frame.
            if (!ball_i.dx_pos && ball_i.x == X_PADDLE_HIT && y_overlap(ball_i.y, y_paddle_i)) begin
                ball_o.dx_pos = 1'b1;
            end else if (ball_i.dx_pos && ball_i.x == X_AI_HIT && y_overlap(ball_i.y, y_ai_i)) begin
                ball_o.dx_pos = 1'b0;
            end else begin
                ball_o.x = ball_i.dx_pos ? ball_i.x + 8'd1 : ball_i.x - 8'd1;
            end

            if (!ball_i.dy_pos && ball_i.y == '0) begin
                ball_o.dy_pos = 1'b1;
            end else if (ball_i.dy_pos && ball_i.y == Y_BALL_MAX) begin
                ball_o.dy_pos = 1'b0;
            end else begin
                ball_o.y = ball_i.dy_pos ? ball_i.y + 7'd1 : ball_i.y - 7'd1;
            end
        end
    end

endmodule

// File: rtl/pong_game_controller.sv
// Per-frame Pong sequencer: paddles on the tick edge, ball step on the following edge.
module pong_game_controller
    import pong_pkg::*;
#(
    parameter int unsigned PADDLE_SPEED = 2,
    parameter int unsigned AI_SPEED     = 1,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 7
) (
    input  logic                   VGA_CLK,
    input  logic                   RESET_N,
    pong_game_controller_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    state_e               state_q, state_d;
    phase_e               phase_q, phase_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    ball_t                ball_q, ball_d, ball_step;
    logic [Y_W-1:0]       y_paddle_q, y_paddle_d, paddle_nxt;
    logic [Y_W-1:0]       y_ai_q, y_ai_d, ai_nxt;
    logic [SCORE_W-1:0]   player_score_q, player_score_d;
    logic [SCORE_W-1:0]   ai_score_q, ai_score_d;
    logic                 game_over_q, game_over_d;
    logic                 point_ai_c, point_player_c;
    logic [8:0]           yp_ext, ya_mid, yb_mid;

    pong_ball_physics u_physics (
        .ball_i         (ball_q),
        .y_paddle_i     (y_paddle_q),
        .y_ai_i         (y_ai_q),
        .ball_o         (ball_step),
        .point_ai_c     (point_ai_c),
        .point_player_c (point_player_c)
    );

    // Candidate paddle positions for this tick, clamped to the paddle range.
    always_comb begin
        yp_ext     = 9'(y_paddle_q);
        ya_mid     = 9'(y_ai_q) + 9'(PADDLE_H / 2);
        yb_mid     = 9'(ball_q.y) + 9'(BALL_SZ / 2);
        paddle_nxt = y_paddle_q;
        ai_nxt     = y_ai_q;
        if (bus.btn_up && !bus.btn_down) begin
            paddle_nxt = (yp_ext < 9'(PADDLE_SPEED)) ? '0 : y_paddle_q - Y_W'(PADDLE_SPEED);
        end else if (bus.btn_down && !bus.btn_up) begin
            paddle_nxt = (yp_ext + 9'(PADDLE_SPEED) > 9'(Y_PADDLE_MAX)) ? Y_PADDLE_MAX
                                                                       : y_paddle_q + Y_W'(PADDLE_SPEED);
        end
        if (ya_mid < yb_mid) begin
            ai_nxt = (9'(y_ai_q) + 9'(AI_SPEED) > 9'(Y_PADDLE_MAX)) ? Y_PADDLE_MAX
                                                                   : y_ai_q + Y_W'(AI_SPEED);
        end else if (ya_mid > yb_mid) begin
            ai_nxt = (9'(y_ai_q) < 9'(AI_SPEED)) ? '0 : y_ai_q - Y_W'(AI_SPEED);
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        ball_d         = ball_q;
        y_paddle_d     = y_paddle_q;
        y_ai_d         = y_ai_q;
        player_score_d = player_score_q;
        ai_score_d     = ai_score_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end
            end
            ST_SERVE, ST_PLAY: begin
                if (phase_q == PH_IDLE) begin
                    if (bus.frame_tick) begin
                        y_paddle_d = paddle_nxt;
                        y_ai_d     = ai_nxt;
                        if (state_q == ST_PLAY) begin
                            phase_d = PH_BALL;
                        end else begin
                            phase_d = PH_HOLD;
                            if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                                state_d = ST_PLAY;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end else begin
                    // Second edge of the frame; a tick seen here is dropped.
                    phase_d = PH_IDLE;
                    if (phase_q == PH_BALL) begin
                        ball_d = ball_step;
                        if (point_ai_c) begin
                            ai_score_d = ai_score_q + SCORE_W'(1);
                            state_d    = (ai_score_d == SCORE_W'(WIN_SCORE)) ? ST_GAME_OVER : ST_SERVE;
                        end else if (point_player_c) begin
                            player_score_d = player_score_q + SCORE_W'(1);
                            state_d        = (player_score_d == SCORE_W'(WIN_SCORE)) ? ST_GAME_OVER : ST_SERVE;
                        end
                    end
                end
                if (state_q == ST_SERVE) begin
                    ball_d.x = X_CENTRE;
                    ball_d.y = Y_CENTRE;
                end
            end
            ST_GAME_OVER: begin
                if (bus.start) begin
                    state_d        = ST_SERVE;
                    cnt_d          = '0;
                    player_score_d = '0;
                    ai_score_d     = '0;
                    ball_d.x       = X_CENTRE;
                    ball_d.y       = Y_CENTRE;
                    ball_d.dx_pos  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        game_over_d = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= ST_IDLE;
            phase_q        <= PH_IDLE;
            cnt_q          <= '0;
            ball_q         <= '{x: X_CENTRE, y: Y_CENTRE, dx_pos: 1'b1, dy_pos: 1'b1};
            y_paddle_q     <= Y_PADDLE_INIT;
            y_ai_q         <= Y_PADDLE_INIT;
            player_score_q <= '0;
            ai_score_q     <= '0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            ball_q         <= ball_d;
            y_paddle_q     <= y_paddle_d;
            y_ai_q         <= y_ai_d;
            player_score_q <= player_score_d;
            ai_score_q     <= ai_score_d;
            game_over_q    <= game_over_d;
        end
    end

    assign bus.x_ball       = ball_q.x;
    assign bus.y_ball       = ball_q.y;
    assign bus.x_paddle     = X_PADDLE;
    assign bus.y_paddle     = y_paddle_q;
    assign bus.x_ai         = X_AI;
    assign bus.y_ai         = y_ai_q;
    assign bus.player_score = player_score_q;
    assign bus.ai_score     = ai_score_q;
    assign bus.game_over    = game_over_q;

endmodule
